aes_key_expansion: RTL and testbench
====================================

# aes_key_expansion

Iterative AES-128 key schedule that sits directly upstream of the round pipeline. It accepts one 128-bit cipher key via a valid/ready handshake and computes one round key per clock. Round keys 0 through 10 are held in a register bank that drives the `round_key` inputs of the initial AddRoundKey stage, the nine full rounds and `aes_final_round`. `keys_valid` marks when the whole bank is stable and the pipeline may be fed.

## Interface
- No parameters. The block is fixed to AES-128: Nk=4, Nr=10, 11 round keys.
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Reset, synchronous and active-high.
- `key_in`  in  128  Cipher key. Word w0 = [127:96]; byte 0 = [127:120] (FIPS-197 order, same as the state byte order).
- `key_valid`  in  1  `key_in` is valid this cycle.
- `key_ready`  out  1  Block can accept a key. Combinational decode of state: 1 in IDLE and DONE, 0 in EXPAND.
- `keys_valid`  out  1  All 11 round keys are complete and stable.
- `busy`  out  1  High in EXPAND.
- `round_keys`  out  1408  Flattened bank; round key i = `round_keys[128*i +: 128]`, i = 0..10.

## Operation
- FSM states: IDLE, EXPAND, DONE.
  - IDLE: wait for a handshake.
  - EXPAND: generate rk1..rk10.
  - DONE: hold the bank with `keys_valid`=1.
- Handshake: a key is accepted on an edge where `key_valid` && `key_ready`. On that edge:
  - rk0 <= `key_in`
  - 4-bit round counter `rnd` <= 1
  - state <= EXPAND
  - `keys_valid` <= 0
- EXPAND, each edge:
  - rk[rnd] is computed from rk[rnd-1] and registered into the bank at index `rnd`.
  - `rnd` increments.
  - When rk10 is written, state <= DONE and `keys_valid` <= 1 on the same edge.
- Per-round computation, with w0..w3 taken from rk[rnd-1]:
  - t = SubWord(RotWord(w3)) ^ {Rcon[rnd], 24'h0}
  - RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- SubWord is 4 instances of a combinational AES forward S-box lookup, local to this block. The clocked `sub_bytes` is not reused.
- Only one bank entry is written per cycle. Entries not being written hold their value.
- Re-key from DONE is allowed. Acceptance immediately drops `keys_valid`, and a full expansion restarts.
- While in EXPAND, `key_valid` is ignored (`key_ready`=0). There is no queuing; the upstream source must hold the key until the handshake.
- Downstream rule: the pipeline consumers must not launch data while `keys_valid`=0. This block does not stall the pipeline.

## Timing
- Reset values, on any edge with `rst`=1:
  - state = IDLE, `rnd` = 0, all 11 bank entries = 0
  - `keys_valid` = 0, `busy` = 0, `key_ready` = 1
- Reset has priority over the handshake and over an expansion in progress. Reset during EXPAND aborts the expansion and clears the bank; no partial keys survive.
- Latency:
  - Key accepted at edge E0: rk0 is visible after E0.
  - rk_i is visible after edge Ei.
  - `keys_valid` = 1 after E10, i.e. 10 cycles after acceptance.
- Throughput: one key per 11 cycles minimum (E0 accept, E1..E10 expand; next accept possible at E11 from DONE).
- `busy` is 1 exactly for the 10 cycles following E0. `key_ready` = !`busy`.
- `round_keys` is a direct register output with no combinational path from `key_in`.
- `rnd` never exceeds 10. Entering DONE freezes `rnd` and the bank.

## Test plan
- Reset, then idle with `key_valid`=0 -> `key_ready`=1, `keys_valid`=0, `busy`=0, `round_keys`=0.
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c -> after 10 cycles:
  - `keys_valid`=1
  - rk0 = key
  - rk1 = a0fafe1788542cb123a339392a6c7605
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6
- All-zero key:
  - rk1 = 62636363626363636263636362636363
  - rk10 = b4ef5bcb3e92e21123e951cf6f8f188e
- `key_valid` held high with a different key during EXPAND -> ignored; final bank matches the first key only; `key_ready`=0 throughout.
- Re-key from DONE (A.1 key, then zero key) -> `keys_valid` drops on the accept edge, returns after 10 cycles, and the bank holds the zero-key schedule.
- Assert `rst` for one cycle at `rnd`=5 -> next cycle IDLE, bank all zero, `keys_valid`=0; a subsequent A.1 expansion completes correctly.

Source files
------------

// File: rtl/aes_key_expansion.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expansion
// Description : Iterative AES-128 key schedule. Accepts one 128-bit cipher
//               key over a valid/ready handshake and produces one round key
//               per clock into an 11-entry register bank (rk0..rk10).
// Ports       : clk, rst         - clock, synchronous active-high reset
//               key_in           - cipher key, w0 = [127:96], byte 0 = [127:120]
//               key_valid        - key_in is valid this cycle
//               key_ready        - block can accept a key (IDLE or DONE)
//               keys_valid       - all 11 round keys complete and stable
//               busy             - expansion in progress
//               round_keys       - flattened bank, rk i = [128*i +: 128]
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expansion (
    input  logic            clk,
    input  logic            rst,
    input  logic [127:0]    key_in,
    input  logic            key_valid,
    output logic            key_ready,
    output logic            keys_valid,
    output logic            busy,
    output logic [1407:0]   round_keys
);

    localparam int c_NUM_KEYS = 11;
    localparam logic [3:0] c_LAST_RND = 4'd10;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [3:0]     r_rnd;
    logic           r_keys_valid;
    logic [127:0]   r_bank [c_NUM_KEYS];

    logic           w_accept;
    logic           w_last;
    logic [127:0]   w_prev;
    logic [31:0]    w_rot;
    logic [31:0]    w_sub;
    logic [7:0]     w_rcon;
    logic [31:0]    w_t;
    logic [31:0]    w_n0;
    logic [31:0]    w_n1;
    logic [31:0]    w_n2;
    logic [31:0]    w_n3;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {b, 3'b000};
        return c_SBOX[11'd2047 - idx -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Handshake / status decode
    // ------------------------------------------------------------------
    assign busy       = (r_state == EXPAND);
    assign key_ready  = ~busy;
    assign keys_valid = r_keys_valid;
    assign w_accept   = key_valid && key_ready;
    assign w_last     = (r_rnd == c_LAST_RND);

    // ------------------------------------------------------------------
    // Round computation: previous key is rk[rnd-1]. Selected with an
    // explicit compare loop so rnd=0 never produces an out-of-range index.
    // ------------------------------------------------------------------
    always_comb begin
        w_prev = '0;
        for (int i = 0; i < c_NUM_KEYS - 1; i++) begin
            if (r_rnd == 4'(i + 1)) begin
                w_prev = r_bank[i];
            end
        end
    end

    assign w_rot  = {w_prev[23:0], w_prev[31:24]};
    assign w_sub  = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                     sbox(w_rot[15:8]),  sbox(w_rot[7:0])};
    assign w_rcon = rcon(r_rnd);
    assign w_t    = w_sub ^ {w_rcon, 24'h0};
    assign w_n0   = w_prev[127:96] ^ w_t;
    assign w_n1   = w_prev[95:64]  ^ w_n0;
    assign w_n2   = w_prev[63:32]  ^ w_n1;
    assign w_n3   = w_prev[31:0]   ^ w_n2;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = EXPAND;
            EXPAND:  if (w_last)   w_state_next = DONE;
            DONE:    if (w_accept) w_state_next = EXPAND;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Round counter, bank and keys_valid
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rnd        <= 4'd0;
            r_keys_valid <= 1'b0;
            for (int i = 0; i < c_NUM_KEYS; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_accept) begin
            r_bank[0]    <= key_in;
            r_rnd        <= 4'd1;
            r_keys_valid <= 1'b0;
        end else if (r_state == EXPAND) begin
            for (int i = 1; i < c_NUM_KEYS; i++) begin
                if (r_rnd == 4'(i)) begin
                    r_bank[i] <= {w_n0, w_n1, w_n2, w_n3};
                end
            end
            // rnd stops at 10 so DONE holds a frozen, in-range counter.
            if (w_last) begin
                r_keys_valid <= 1'b1;
            end else begin
                r_rnd <= r_rnd + 4'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < c_NUM_KEYS; gi++) begin : g_out
            assign round_keys[128*gi +: 128] = r_bank[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expansion.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_expansion
// Description : Directed, self-checking bench for aes_key_expansion using
//               FIPS-197 reference schedules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expansion;

    logic            clk;
    logic            rst;
    logic [127:0]    key_in;
    logic            key_valid;
    logic            key_ready;
    logic            keys_valid;
    logic            busy;
    logic [1407:0]   round_keys;

    int n_tests;
    int n_fail;

    aes_key_expansion dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .keys_valid (keys_valid),
        .busy       (busy),
        .round_keys (round_keys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;

    localparam logic [127:0] c_A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_Z_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] c_Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    function automatic logic [127:0] rk(input int i);
        return round_keys[128*i +: 128];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge. Launches key k, then follows the ten expansion
    // cycles. With hold_other set, key_valid stays high carrying 'other'
    // throughout EXPAND and must be ignored.
    task automatic expand(input string tag, input logic [127:0] k,
                          input logic [127:0] e1, input logic [127:0] e10,
                          input bit hold_other, input logic [127:0] other);
        int bad;
        int guard;
        guard = 0;
        while (!key_ready && guard < 20) begin
            @(posedge clk); @(negedge clk);
            guard++;
        end
        chk({tag, "_ready_before_accept"}, 128'(key_ready), 128'd1);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        if (hold_other) key_in = other;
        else            key_valid = 1'b0;
        chk({tag, "_rk0"},        rk(0),              k);
        chk({tag, "_kv_drop"},    128'(keys_valid),   128'd0);
        chk({tag, "_busy_e0"},    128'(busy),         128'd1);
        chk({tag, "_ready_e0"},   128'(key_ready),    128'd0);
        bad = 0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); @(negedge clk);
            if (busy !== 1'b1 || keys_valid !== 1'b0 || key_ready !== 1'b0) bad++;
        end
        chk({tag, "_expand_cycles_bad"}, 128'(bad), 128'd0);
        @(posedge clk); @(negedge clk);
        key_valid = 1'b0;
        chk({tag, "_kv_e10"},     128'(keys_valid),   128'd1);
        chk({tag, "_busy_e10"},   128'(busy),         128'd0);
        chk({tag, "_ready_e10"},  128'(key_ready),    128'd1);
        chk({tag, "_rk0_final"},  rk(0),              k);
        chk({tag, "_rk1"},        rk(1),              e1);
        chk({tag, "_rk10"},       rk(10),             e10);
        // DONE must hold the bank frozen.
        @(posedge clk); @(negedge clk);
        chk({tag, "_rk10_hold"},  rk(10),             e10);
        chk({tag, "_kv_hold"},    128'(keys_valid),   128'd1);
    endtask

    vec_t vecs [2];

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;

        vecs[0] = '{key: c_A1_KEY, rk1: c_A1_RK1, rk10: c_A1_RK10};
        vecs[1] = '{key: 128'h0,   rk1: c_Z_RK1,  rk10: c_Z_RK10};

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("reset_key_ready",  128'(key_ready),        128'd1);
        chk("reset_keys_valid", 128'(keys_valid),       128'd0);
        chk("reset_busy",       128'(busy),             128'd0);
        chk("reset_bank_zero",  128'(round_keys == '0), 128'd1);

        // Table: the second entry starts from DONE, covering re-key.
        for (int i = 0; i < 2; i++) begin
            expand($sformatf("vec%0d", i), vecs[i].key, vecs[i].rk1, vecs[i].rk10, 1'b0, '0);
        end

        // key_valid held with a different key during EXPAND is ignored
        expand("ignore", c_A1_KEY, c_A1_RK1, c_A1_RK10, 1'b1, 128'h0);

        // Reset mid-expansion at rnd=5
        key_in    = c_Z_RK10;
        key_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        key_valid = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        chk("midrst_busy_before", 128'(busy), 128'd1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy",       128'(busy),             128'd0);
        chk("midrst_key_ready",  128'(key_ready),        128'd1);
        chk("midrst_keys_valid", 128'(keys_valid),       128'd0);
        chk("midrst_bank_zero",  128'(round_keys == '0), 128'd1);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("midrst_idle_kv",    128'(keys_valid),       128'd0);

        expand("after_rst", c_A1_KEY, c_A1_RK1, c_A1_RK10, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
